// File: rtl/sfir_pkg.sv
// Shared definitions for the symmetric FIR datapath and its sequencer.
// The datapath top and the sequencer both take their default latency from
// here so the two cannot drift apart.
package sfir_pkg;

  // Sequencer states; the encoding is fixed so other blocks can decode it
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_t;

  localparam int DSIZE_DEFAULT = 16;
  localparam int NBTAP_DEFAULT = 4;

  // Enabled-cycle latency of the systolic datapath: the 2*nbtap delay line
  // plus the pre-add, multiply and accumulate register stages
  function automatic int dp_lat_for(input int nbtap);
    return 2 * nbtap + 3;
  endfunction

  localparam int DP_LAT_DEFAULT = dp_lat_for(NBTAP_DEFAULT);

endpackage

// File: rtl/sfir_tag_pipe.sv
// One valid bit per datapath stage. The tags move together with the
// datapath, so the bit that falls out of the last stage says whether the
// current datapath result belongs to a real sample.
module sfir_tag_pipe #(
  parameter int depth = 11
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [depth-1:0] tags;

  // Shift in step with the datapath; a clear drops every in-flight tag
  always_ff @(posedge clk) begin
    if (clr) begin
      tags <= '0;
    end else if (en) begin
      tags <= {tags[depth-2:0], din};
    end
  end

  assign dout = tags[depth-1];

endmodule

// File: rtl/sfir_seq.sv
// Sequencer for the systolic symmetric FIR datapath. It owns the datapath
// clock-enable, clears the unreset datapath registers by pushing zeros
// through after reset, tracks which results are real, freezes the datapath
// under output back-pressure, and drains in-flight samples on a flush.
module sfir_seq
  import sfir_pkg::*;
#(
  parameter int dsize  = DSIZE_DEFAULT,
  parameter int nbtap  = NBTAP_DEFAULT,
  parameter int dp_lat = dp_lat_for(nbtap)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [dsize-1:0] in_data,
  input  logic             flush,
  output logic             dp_ce,
  output logic [dsize-1:0] dp_in,
  input  logic [dsize-1:0] dp_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [dsize-1:0] out_data,
  output logic             busy
);

  // The counter must reach dp_lat-1, the last advance of a clear or drain
  localparam int            cw       = $clog2(dp_lat + 1);
  localparam logic [cw-1:0] cnt_last = cw'(dp_lat - 1);

  seq_state_t    state;
  logic [cw-1:0] cnt;
  logic          adv;
  logic          accept;
  logic          stall;

  // A real result that downstream refuses must not be overwritten
  assign stall  = out_valid && !out_ready;
  assign accept = in_valid && in_ready;

  // Per-state handshake and advance decode; RUN only moves on a new sample
  always_comb begin
    in_ready = 1'b0;
    dp_in    = '0;
    adv      = 1'b0;
    case (state)
      CLEAR: begin
        adv = 1'b1;
      end
      RUN: begin
        in_ready = !stall;
        dp_in    = in_data;
        adv      = in_valid && !stall;
      end
      FLUSH: begin
        adv = !stall;
      end
      default: begin
        adv = 1'b0;
      end
    endcase
  end

  // The datapath must hold still while reset is asserted
  assign dp_ce    = adv && !rst;
  assign out_data = dp_out;
  assign busy     = (state != RUN);

  // State and counter: CLEAR and FLUSH each last exactly dp_lat advances
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == cnt_last) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + cw'(1);
          end
        end
        RUN: begin
          if (flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (adv) begin
            if (cnt == cnt_last) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + cw'(1);
            end
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  sfir_tag_pipe #(
    .depth(dp_lat)
  ) u_tag_pipe (
    .clk (clk),
    .clr (rst),
    .en  (adv),
    .din (accept),
    .dout(out_valid)
  );

endmodule

// File: tb/tb_sfir_seq.sv
// Bench for sfir_seq. The datapath is stood in for by an enabled delay line
// that powers up as X. A reference model tracks the sequencer mode and a
// queue of in-flight samples, each aging by one per datapath advance, and
// predicts every handshake output each cycle.
module tb_sfir_seq;

  localparam int DSIZE = 16;
  localparam int NBTAP = 4;
  localparam int DPLAT = 11;

  typedef enum {M_CLEAR, M_RUN, M_FLUSH} model_mode_t;

  typedef struct {
    logic [DSIZE-1:0] data;
    int               age;
  } flight_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DSIZE-1:0] in_data = '0;
  logic             flush = 1'b0;
  logic             dp_ce;
  logic [DSIZE-1:0] dp_in;
  logic [DSIZE-1:0] dp_out;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DSIZE-1:0] out_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  model_mode_t      mode = M_CLEAR;
  int               clearLeft = DPLAT;
  int               flushLeft = 0;
  int               cycleCount = 0;
  bit               zeroCheckPending = 1'b0;
  flight_t          inflight[$];
  logic [DSIZE-1:0] delivered[$];
  int               deliveredCycle[$];

  // stand-in datapath
  logic [DSIZE-1:0] dl [DPLAT];

  sfir_seq #(
    .dsize (DSIZE),
    .nbtap (NBTAP),
    .dp_lat(DPLAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .dp_ce    (dp_ce),
    .dp_in    (dp_in),
    .dp_out   (dp_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // datapath stand-in: advances only on dp_ce
  always @(posedge clk) begin
    if (dp_ce) begin
      dl[0] <= dp_in;
      for (int i = 1; i < DPLAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign dp_out = dl[DPLAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycleCount);
    end
  endtask

  // one cycle of stimulus; returns mid-cycle so outputs can be inspected
  task automatic applyStimulus(input logic r, input logic iv, input logic [DSIZE-1:0] d,
                               input logic fl, input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
    #1;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      if (!busy) break;
    end
    checkOutput("idle_reached", busy, 1'b0);
  endtask

  // Predict and check every output for the coming edge, then apply that edge to the model
  always @(negedge clk) begin
    bit               eValid, eStall, eReady, eAdv, eAccept, zeroOk;
    logic [DSIZE-1:0] eDpIn;
    cycleCount++;
    eValid = (inflight.size() > 0) && (inflight[0].age == DPLAT - 1);
    eStall = eValid && !out_ready;
    eReady = 1'b0;
    eAdv   = 1'b0;
    eDpIn  = '0;
    case (mode)
      M_CLEAR: eAdv = 1'b1;
      M_RUN: begin
        eReady = !eStall;
        eAdv   = in_valid && eReady;
        eDpIn  = in_data;
      end
      M_FLUSH: eAdv = !eStall;
      default: eAdv = 1'b0;
    endcase
    if (rst) eAdv = 1'b0;

    checkOutput("in_ready", in_ready, eReady);
    checkOutput("dp_ce", dp_ce, eAdv);
    checkOutput("busy", busy, mode != M_RUN);
    checkOutput("out_valid", out_valid, eValid);
    checkOutput("dp_in", dp_in, eDpIn);
    if (eValid) checkOutput("out_data", out_data, inflight[0].data);
    if (zeroCheckPending) begin
      zeroOk = 1'b1;
      for (int i = 0; i < DPLAT; i++) if (dl[i] !== '0) zeroOk = 1'b0;
      checkOutput("clear_zero", zeroOk, 1'b1);
      zeroCheckPending = 1'b0;
    end

    if (rst) begin
      mode      = M_CLEAR;
      clearLeft = DPLAT;
      inflight.delete();
    end else begin
      eAccept = in_valid && eReady;
      if (eAdv) begin
        if (eValid) begin
          delivered.push_back(inflight[0].data);
          deliveredCycle.push_back(cycleCount);
          inflight.delete(0);
        end
        foreach (inflight[i]) inflight[i].age = inflight[i].age + 1;
      end
      if (eAccept) inflight.push_back('{data: in_data, age: 0});
      case (mode)
        M_CLEAR: begin
          clearLeft--;
          if (clearLeft == 0) begin
            mode             = M_RUN;
            zeroCheckPending = 1'b1;
          end
        end
        M_RUN: begin
          if (flush) begin
            mode      = M_FLUSH;
            flushLeft = DPLAT;
          end
        end
        M_FLUSH: begin
          if (eAdv) begin
            flushLeft--;
            if (flushLeft == 0) mode = M_RUN;
          end
        end
        default: mode = M_CLEAR;
      endcase
    end
  end

  initial begin
    int         next, acc0, base, ceCnt, vCnt, busyCnt, n;
    bit         seen;
    logic [4:0] pat;

    // reset held for two cycles, then the clear sequence
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("rst_ce", dp_ce, 1'b0);
    checkOutput("rst_ready", in_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_valid", out_valid, 1'b0);
    ceCnt = 0;
    for (int i = 0; i < DPLAT; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      if (dp_ce) ceCnt++;
      checkOutput("clr_ready", in_ready, 1'b0);
      checkOutput("clr_busy", busy, 1'b1);
      checkOutput("clr_dp_in", dp_in, 16'h0);
    end
    checkOutput("clr_ce_cycles", ceCnt, DPLAT);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("ready_after_clear", in_ready, 1'b1);
    checkOutput("busy_after_clear", busy, 1'b0);

    // continuous stream 1..20, flush with the last sample
    base = delivered.size();
    next = 1;
    acc0 = 0;
    for (int c = 0; c < 100 && next <= 20; c++) begin
      applyStimulus(1'b0, 1'b1, 16'(next), next == 20, 1'b1);
      if (in_ready) begin
        if (next == 1) acc0 = cycleCount;
        next++;
      end
    end
    checkOutput("stream_accepted", next, 21);
    waitIdle();
    checkOutput("stream_count", delivered.size() - base, 20);
    if (delivered.size() - base >= 20) begin
      checkOutput("first_latency", deliveredCycle[base] - acc0, DPLAT);
      for (int k = 0; k < 20; k++) checkOutput("stream_data", delivered[base+k], k + 1);
      checkOutput("stream_contig", deliveredCycle[base+19] - deliveredCycle[base], 19);
    end

    // back-pressure for five cycles with the pipe full
    base = delivered.size();
    next = 21;
    for (int c = 0; c < 100 && next <= 32; c++) begin
      applyStimulus(1'b0, 1'b1, 16'(next), 1'b0, 1'b1);
      if (in_ready) next++;
    end
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b0, 1'b1, 16'(next), 1'b0, 1'b0);
      checkOutput("bp_ready", in_ready, 1'b0);
      checkOutput("bp_ce", dp_ce, 1'b0);
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_data", out_data, 16'd22);
    end
    for (int c = 0; c < 100 && next <= 40; c++) begin
      applyStimulus(1'b0, 1'b1, 16'(next), next == 40, 1'b1);
      if (in_ready) next++;
    end
    waitIdle();
    checkOutput("bp_count", delivered.size() - base, 20);
    if (delivered.size() - base >= 20) begin
      for (int k = 0; k < 20; k++) checkOutput("bp_stream", delivered[base+k], k + 21);
    end

    // three samples then a flush; a second flush inside FLUSH is ignored
    base = delivered.size();
    for (int v = 5; v <= 7; v++) begin
      applyStimulus(1'b0, 1'b1, 16'(v), 1'b0, 1'b1);
      checkOutput("fl_accept", in_ready, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("fl_req_busy", busy, 1'b0);
    busyCnt = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b0, '0, c == 3, 1'b1);
      if (!busy) break;
      busyCnt++;
      checkOutput("fl_ce", dp_ce, 1'b1);
    end
    checkOutput("fl_busy_cycles", busyCnt, DPLAT);
    checkOutput("fl_ready_after", in_ready, 1'b1);
    checkOutput("fl_count", delivered.size() - base, 3);
    if (delivered.size() - base >= 3) begin
      for (int k = 0; k < 3; k++) checkOutput("fl_data", delivered[base+k], k + 5);
    end

    // reset with five samples in flight
    base = delivered.size();
    for (int v = 0; v < 5; v++) applyStimulus(1'b0, 1'b1, 16'(100 + v), 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
    checkOutput("mr_ce", dp_ce, 1'b0);
    ceCnt = 0;
    vCnt  = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
      if (dp_ce) ceCnt++;
      if (out_valid) vCnt++;
    end
    checkOutput("mr_ready_seen", seen, 1'b1);
    checkOutput("mr_clear_cycles", ceCnt, DPLAT);
    checkOutput("mr_no_valid", vCnt, 0);
    checkOutput("mr_discarded", delivered.size() - base, 0);
    for (int v = 0; v < 6; v++) applyStimulus(1'b0, 1'b1, 16'(200 + v), v == 5, 1'b1);
    waitIdle();
    checkOutput("mr_resume_count", delivered.size() - base, 6);
    if (delivered.size() - base >= 6) begin
      for (int k = 0; k < 6; k++) checkOutput("mr_resume_data", delivered[base+k], k + 200);
    end

    // gappy input: in_valid pattern 1,0,1,1,0 twice
    base = delivered.size();
    pat  = 5'b01101;
    n    = 0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 5; p++) begin
        applyStimulus(1'b0, pat[p], 16'(50 + n), 1'b0, 1'b1);
        checkOutput("gap_ce", dp_ce, pat[p]);
        if (pat[p]) n++;
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    waitIdle();
    checkOutput("gap_count", delivered.size() - base, n);
    if (delivered.size() - base >= n) begin
      for (int k = 0; k < n; k++) checkOutput("gap_data", delivered[base+k], k + 50);
    end

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 149) == 0, 1'($urandom), 16'($urandom),
                    $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    waitIdle();
    checkOutput("rand_drained", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
